// File: rtl/rr_resp_router.sv
// Per-slave response router: in-order tag FIFO of {master_id, cmd}, routes s_ack/s_rdata to the owning master.
// Optional watchdog forced-error response enabled by defining RR_RESP_TIMEOUT_EN.
module rr_resp_router #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        perm0,
   input  logic        perm1,
   input  logic        cmd_to,
   input  logic        s_ack,
   input  logic [31:0] s_rdata,
   output logic        ack0,
   output logic [31:0] rdata0,
   output logic        err0,
   output logic        ack1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic        stall,
   output logic        proto_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("rr_resp_router: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
   end

   // Entry layout: bit 1 = master id, bit 0 = cmd (1 = write)
   logic [1:0]    tag_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   logic          empty;
   logic          full;
   logic [1:0]    head;
   logic          perm_any;
   logic          push;
   logic          pop;
   logic          expire;
   logic          perr_set;
   logic [31:0]   resp_data;

`ifdef RR_RESP_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wd_cnt;

   always_comb begin
      expire = !empty && !s_ack && (wd_cnt == TW'(TIMEOUT - 1));
   end

   // Clearing while empty also covers a push into an empty FIFO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
      end else if (empty || s_ack || expire) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + TW'(1);
      end
   end
`else
   always_comb begin
      expire = 1'b0;
   end
`endif

   always_comb begin
      empty     = (count == '0);
      full      = (count == CW'(DEPTH));
      head      = tag_mem[rd_ptr];
      perm_any  = perm0 | perm1;
      pop       = (s_ack && !empty) || expire;
      push      = perm_any && (!full || pop);
      count_nxt = count + CW'(push) - CW'(pop);
      perr_set  = (perm0 && perm1) || (perm_any && full && !pop) || (s_ack && empty);
      if (expire) begin
         resp_data = 32'hDEAD_BEEF;
      end else if (head[0]) begin
         resp_data = '0;
      end else begin
         resp_data = s_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= {~perm0, cmd_to};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         stall     <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_nxt;
         stall <= (count_nxt == CW'(DEPTH));
         if (perr_set) begin
            proto_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         ack0 <= pop && !head[1];
         ack1 <= pop && head[1];
         if (pop && !head[1]) begin
            rdata0 <= resp_data;
         end
         if (pop && head[1]) begin
            rdata1 <= resp_data;
         end
      end
   end

`ifdef RR_RESP_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err0 <= 1'b0;
         err1 <= 1'b0;
      end else begin
         err0 <= expire && !head[1];
         err1 <= expire && head[1];
      end
   end
`else
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

endmodule
